fetch_decode_q: RTL and testbench
=================================

# fetch_decode_q

Parametrised fetch/decode front end for the three-stage RV32I core; it replaces the single-register F/D stage. It issues in-order instruction fetches over a valid/ready memory channel and buffers responses in a DEPTH-entry prefetch queue. It decodes the queue head into the execute-stage register under ex_ready back-pressure, and supports PC redirect with in-flight squash and a sticky exception with cause.

## Interface
- RESETVEC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch queue entries; power of two, 2..16
- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address (word-aligned)
- imem_rsp_valid  in  1  response valid, in order, latency L>=1 after acceptance
- imem_rdata  in  32  instruction word
- redir_valid  in  1  redirect from execute (taken branch/jump)
- redir_pc  in  32  redirect target
- ex_ready  in  1  execute consumes ex register this cycle
- ex_valid  out  1  ex register holds a decoded instruction
- ex_pc  out  32  PC of decoded instruction
- ex_imm  out  32  sign/zero-extended immediate
- ex_src1_sel, ex_src2_sel, ex_dst_sel  out  5 each  rs1, rs2, rd fields
- ex_alu_op  out  3  funct3
- ex_ctrl  out  11  {imm_sel, subtype, memwr, mem2reg, alu, csr, lui, auipc, jal, jalr, branch}, MSB first
- exception  out  1  sticky exception flag
- exc_cause  out  2  01 illegal instruction, 10 misaligned redirect
- exc_pc  out  32  PC of faulting instruction / misaligned target

## Operation
- Reset values: fetch_pc=RESETVEC, rsp_pc=RESETVEC, queue empty, outstanding=0, drop=0; ex_valid=0, ex_pc=RESETVEC, all other ex_* = 0, exception=0, exc_cause=0, exc_pc=0.
- Credit: imem_req_valid = !exception && (occupancy + outstanding < DEPTH). imem_addr=fetch_pc. On accept, fetch_pc+=4 (mod 2^32) and outstanding+=1.
- Response: if drop>0, discard and decrement drop. Otherwise push {rsp_pc, imem_rdata} and rsp_pc+=4. Outstanding decrements in either case.
- Decode load condition: head valid, !exception, and (!ex_valid || ex_ready). Then the head is popped into the ex register, ex_valid=1. If ex_ready && nothing loads, ex_valid->0.
- Decode rules (RV32I): imm per U/J/I/B/S format; ARITHI shifts zero-extend shamt[4:0]; SYSTEM zero-extends imm12. imm_sel = JALR|LOAD|ARITHI. subtype = inst[30] except ARITHI funct3=000. csr = SYSTEM && imm12 not in {0,1}.
- Illegal opcode at head when it would load: do not load; set exception=1, exc_cause=01, exc_pc=head pc; ex_valid follows the ex_ready rule.
- Redirect (highest priority): queue flushed, ex_valid->0, drop=outstanding (excluding any response sampled this same edge, which is itself discarded), fetch_pc=rsp_pc=redir_pc. A request accepted on the same edge is counted in drop.
- redir_pc[1:0]!=0: perform flush, then set exception=1, exc_cause=10, exc_pc=redir_pc.
- Exception is sticky until resetb; it blocks new requests and decode. Outstanding responses are still counted and discarded.
- Simultaneous push and pop of the queue is legal at any occupancy, including full (pop frees the slot first).

## Timing
- Request accepted at edge n with memory latency L -> response sampled at edge n+L -> into ex register at edge n+L+1 if the queue was empty and the ex register free.
- Sustained 1 instr/cycle when DEPTH >= L+2 and ex_ready=1.
- Redirect sampled at edge r -> imem_addr=redir_pc from cycle r+1; first new ex_valid no earlier than edge r+L+2.
- Reset asserted mid-operation clears all state asynchronously. Responses to pre-reset requests are the memory's responsibility to cancel.

## Test plan
- L=1, ex_ready=1, 8 sequential ADDIs from RESETVEC=0 -> ex_valid rises after edge 3, ex_pc 0,4,...,28 on consecutive cycles, no bubbles.
- ex_ready=0 for 10 cycles -> imem_req_valid low once occupancy+outstanding=DEPTH; no loss or reordering after release.
- L=3, redirect to 0x100 while 3 outstanding -> 3 responses discarded, next ex_pc=0x100.
- Redirect coincident with response and request acceptance -> both squashed, next ex_pc=redir_pc.
- Opcode 7'b0000000 at pc 0x8 -> exception=1, exc_cause=01, exc_pc=0x8, imem_req_valid stays 0.
- redir_pc=0x102 -> exc_cause=10, exc_pc=0x102. ARITHI SRAI x1,x2,5 -> ex_imm=5, subtype=1, imm_sel=1.

Source files
------------

// File: rtl/fetch_decode_q.sv
// fetch_decode_q: in-order fetch over a valid/ready channel, prefetch
// queue, RV32I decode into the execute register, redirect and exceptions.
module fetch_decode_q #(
  parameter logic [31:0] RESETVEC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_src1_sel,
  output logic [4:0]  ex_src2_sel,
  output logic [4:0]  ex_dst_sel,
  output logic [2:0]  ex_alu_op,
  output logic [10:0] ex_ctrl,
  output logic        exception,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]   fetch_pc, rsp_pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop, out_nxt;
  logic [CW:0]   inflight;
  logic          req_fire, push, can_load, load, illegal_hit;
  logic [31:0]   head_pc, head_inst;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_arithi, is_arith, is_fence, is_system;
  logic        legal, shift, sub, csr;
  logic [31:0] imm;
  logic [10:0] ctrl;

  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !exception && (inflight < FULL);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_nxt        = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign push           = imem_rsp_valid && (drop == '0) &&
                          !exception && !redir_valid;

  assign head_pc   = q_pc[rd_ptr];
  assign head_inst = q_inst[rd_ptr];
  assign can_load  = (count != '0) && !exception && !redir_valid &&
                     (!ex_valid || ex_ready);
  assign load        = can_load && legal;
  assign illegal_hit = can_load && !legal;

  // Decode the queue head into immediate, control bits and legality.
  always_comb begin
    op        = head_inst[6:0];
    f3        = head_inst[14:12];
    is_lui    = op == OP_LUI;
    is_auipc  = op == OP_AUIPC;
    is_jal    = op == OP_JAL;
    is_jalr   = op == OP_JALR;
    is_branch = op == OP_BRANCH;
    is_load   = op == OP_LOAD;
    is_store  = op == OP_STORE;
    is_arithi = op == OP_ARITHI;
    is_arith  = op == OP_ARITH;
    is_fence  = op == OP_FENCE;
    is_system = op == OP_SYSTEM;
    legal = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
            is_store | is_arithi | is_arith | is_fence | is_system;
    shift = is_arithi && (f3 == 3'b001 || f3 == 3'b101);
    sub   = head_inst[30] && !(is_arithi && f3 == 3'b000);
    csr   = is_system && (head_inst[31:21] != '0);
    imm   = '0;
    unique case (1'b1)
      is_lui, is_auipc:
        imm = {head_inst[31:12], 12'b0};
      is_jal:
        imm = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
               head_inst[30:21], 1'b0};
      is_branch:
        imm = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
               head_inst[11:8], 1'b0};
      is_store:
        imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      is_system:
        imm = {20'b0, head_inst[31:20]};
      shift:
        imm = {27'b0, head_inst[24:20]};
      is_jalr, is_load, (is_arithi && !shift):
        imm = {{20{head_inst[31]}}, head_inst[31:20]};
      default:
        imm = '0;
    endcase
    ctrl = {is_jalr | is_load | is_arithi, sub, is_store, is_load,
            is_arith | is_arithi, csr, is_lui, is_auipc, is_jal,
            is_jalr, is_branch};
  end

  // Queue storage; entries need no reset since count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= rsp_pc;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  // Fetch address, response tracking, squash counter and queue pointers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fetch_pc    <= RESETVEC;
      rsp_pc      <= RESETVEC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redir_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        drop     <= out_nxt;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && drop != '0)
          drop <= drop - CW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (load)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(load);
      end
    end
  end

  // Execute register: load decoded head, or drain when consumed.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ex_valid    <= 1'b0;
      ex_pc       <= RESETVEC;
      ex_imm      <= '0;
      ex_src1_sel <= '0;
      ex_src2_sel <= '0;
      ex_dst_sel  <= '0;
      ex_alu_op   <= '0;
      ex_ctrl     <= '0;
    end else if (redir_valid) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid    <= 1'b1;
      ex_pc       <= head_pc;
      ex_imm      <= imm;
      ex_src1_sel <= head_inst[19:15];
      ex_src2_sel <= head_inst[24:20];
      ex_dst_sel  <= head_inst[11:7];
      ex_alu_op   <= f3;
      ex_ctrl     <= ctrl;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Sticky exception: first cause wins until reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      exception <= 1'b0;
      exc_cause <= '0;
      exc_pc    <= '0;
    end else if (!exception) begin
      if (redir_valid && redir_pc[1:0] != 2'b00) begin
        exception <= 1'b1;
        exc_cause <= 2'b10;
        exc_pc    <= redir_pc;
      end else if (illegal_hit) begin
        exception <= 1'b1;
        exc_cause <= 2'b01;
        exc_pc    <= head_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_q.sv
// tb_fetch_decode_q: directed bench with a fixed-latency memory model
// and hand-computed expected fetch/decode results.
module tb_fetch_decode_q;
  logic        clk = 1'b0;
  logic        resetb;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_src1_sel, ex_src2_sel, ex_dst_sel;
  logic [2:0]  ex_alu_op;
  logic [10:0] ex_ctrl;
  logic        exception;
  logic [1:0]  exc_cause;
  logic [31:0] exc_pc;

  always #5 clk = ~clk;

  fetch_decode_q #(.RESETVEC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .resetb(resetb),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_src1_sel(ex_src1_sel),
    .ex_src2_sel(ex_src2_sel), .ex_dst_sel(ex_dst_sel),
    .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl), .exception(exception),
    .exc_cause(exc_cause), .exc_pc(exc_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic [31:0] mem [256];
  pend_t       pend [$];
  logic [31:0] got [$];
  int          cyc, lat, acc_cnt, n_chk, n_pass, n;
  logic [31:0] dec_inst [8];
  logic [31:0] dec_imm  [8];
  logic [10:0] dec_ctrl [8];

  function automatic logic [31:0] addi(int i);
    return {12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic set_rsp();
    if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem[pend[0].addr[9:2]];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
    end
  endtask

  task automatic step();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    if (ex_valid && ex_ready) got.push_back(ex_pc);
    @(posedge clk);
    cyc++;
    if (imem_rsp_valid) void'(pend.pop_front());
    if (acc) begin
      pend.push_back('{a, cyc + lat});
      acc_cnt++;
    end
    #1;
    set_rsp();
  endtask

  task automatic do_reset(int l);
    resetb = 1'b0;
    redir_valid = 1'b0;
    redir_pc = '0;
    ex_ready = 1'b1;
    imem_req_ready = 1'b1;
    lat = l;
    pend.delete();
    got.delete();
    acc_cnt = 0;
    imem_rsp_valid = 1'b0;
    imem_rdata = '0;
    #20;
    @(posedge clk);
    #1;
    resetb = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = addi(i);

    // sequential ADDIs, L=1, full throughput
    do_reset(1);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_exc", {exception, exc_cause}, 0);
    chk("rst_req", imem_req_valid, 1);
    chk("rst_addr", imem_addr, 32'h0);
    step();
    step();
    chk("seq_bubble", ex_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("seq_valid", ex_valid, 1);
      chk("seq_pc", ex_pc, 32'(4 * k));
      chk("seq_imm", ex_imm, 32'(k));
    end
    chk("seq_ctrl", ex_ctrl, 11'h440);

    // back-pressure: credit limit then ordered release
    do_reset(1);
    ex_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("bp_acc", acc_cnt, 5);
    chk("bp_req", imem_req_valid, 0);
    chk("bp_ex", {ex_valid, ex_pc}, {1'b1, 32'h0});
    got.delete();
    ex_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("bp_cnt", got.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      chk("bp_order", (i < got.size()) ? got[i] : 32'hdead_beef, 32'(4 * i));

    // L=3 redirect with three requests in flight
    do_reset(3);
    step();
    step();
    redir_valid = 1'b1;
    redir_pc = 32'h100;
    step();
    redir_valid = 1'b0;
    chk("r3_addr", imem_addr, 32'h100);
    chk("r3_ex", ex_valid, 0);
    n = 0;
    while (!ex_valid && n < 20) begin
      step();
      n++;
    end
    chk("r3_lat", n, 5);
    chk("r3_pc", ex_pc, 32'h100);
    step();
    chk("r3_pc2", ex_pc, 32'h104);

    // redirect coincident with response and accepted request
    do_reset(1);
    for (int k = 0; k < 5; k++) step();
    chk("rc_pre", {imem_rsp_valid, imem_req_valid}, 2'b11);
    redir_valid = 1'b1;
    redir_pc = 32'h200;
    step();
    redir_valid = 1'b0;
    chk("rc_ex", ex_valid, 0);
    chk("rc_addr", imem_addr, 32'h200);
    n = 0;
    while (!ex_valid && n < 20) begin
      step();
      n++;
    end
    chk("rc_lat", n, 3);
    chk("rc_pc", ex_pc, 32'h200);

    // illegal opcode at pc 0x8
    mem[2] = 32'h0;
    do_reset(1);
    for (int k = 0; k < 5; k++) step();
    chk("ill_exc", {exception, exc_cause}, 3'b101);
    chk("ill_pc", exc_pc, 32'h8);
    chk("ill_ex", ex_valid, 0);
    for (int k = 0; k < 3; k++) step();
    chk("ill_req", imem_req_valid, 0);
    chk("ill_sticky", {exception, ex_valid, ex_pc}, {2'b10, 32'h4});
    mem[2] = addi(2);
    resetb = 1'b0;
    #3;
    chk("arst_exc", {exception, ex_valid}, 0);
    chk("arst_addr", imem_addr, 32'h0);

    // misaligned redirect
    do_reset(1);
    for (int k = 0; k < 4; k++) step();
    redir_valid = 1'b1;
    redir_pc = 32'h102;
    step();
    redir_valid = 1'b0;
    chk("mis_exc", {exception, exc_cause}, 3'b110);
    chk("mis_pc", exc_pc, 32'h102);
    step();
    chk("mis_req", {imem_req_valid, ex_valid}, 0);

    // decode table
    dec_inst[0] = {7'b0100000, 5'd5, 5'd2, 3'b101, 5'd1, 7'b0010011};
    dec_imm[0]  = 32'h5;
    dec_ctrl[0] = 11'h640;
    dec_inst[1] = {20'h12345, 5'd3, 7'b0110111};
    dec_imm[1]  = 32'h1234_5000;
    dec_ctrl[1] = 11'h010;
    dec_inst[2] = {7'h7f, 5'd5, 5'd6, 3'b010, 5'b11100, 7'b0100011};
    dec_imm[2]  = 32'hffff_fffc;
    dec_ctrl[2] = 11'h300;
    dec_inst[3] = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1,
                   7'b1100011};
    dec_imm[3]  = 32'hffff_fff8;
    dec_ctrl[3] = 11'h201;
    dec_inst[4] = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};
    dec_imm[4]  = 32'h800;
    dec_ctrl[4] = 11'h004;
    dec_inst[5] = {12'h300, 5'd1, 3'b001, 5'd0, 7'b1110011};
    dec_imm[5]  = 32'h300;
    dec_ctrl[5] = 11'h020;
    dec_inst[6] = 32'h0000_0073;
    dec_imm[6]  = 32'h0;
    dec_ctrl[6] = 11'h000;
    dec_inst[7] = {12'd16, 5'd5, 3'b000, 5'd1, 7'b1100111};
    dec_imm[7]  = 32'h10;
    dec_ctrl[7] = 11'h402;
    for (int i = 0; i < 8; i++) mem[i] = dec_inst[i];
    do_reset(1);
    step();
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("dec_pc", ex_pc, 32'(4 * k));
      chk("dec_imm", ex_imm, dec_imm[k]);
      chk("dec_ctrl", ex_ctrl, dec_ctrl[k]);
      if (k == 0)
        chk("dec_fields",
            {ex_src1_sel, ex_src2_sel, ex_dst_sel, ex_alu_op},
            {5'd2, 5'd5, 5'd1, 3'd5});
    end
    chk("dec_exc", exception, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
